// File: rtl/humidity_pkg.sv
// Shared types and constants for the humidity sensor poll scheduler.
// Holds the scheduler state enum, reader state codes and frame byte layout.
package humidity_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_START,
      WAIT_DONE,
      CHECK,
      BACKOFF
   } state_e;

   localparam logic [2:0] RD_IDLE  = 3'd0;
   localparam logic [2:0] RD_START = 3'd1;
   localparam logic [2:0] RD_RX    = 3'd2;
   localparam logic [2:0] RD_DONE  = 3'd3;

   localparam int BYTE_HUM_INT  = 4;
   localparam int BYTE_HUM_DEC  = 3;
   localparam int BYTE_TEMP_INT = 2;
   localparam int BYTE_TEMP_DEC = 1;
   localparam int BYTE_CSUM     = 0;

   function automatic logic [7:0] frame_byte(input logic [39:0] f,
                                             input int idx);
      return f[idx*8 +: 8];
   endfunction

endpackage

// File: rtl/humidity_poll_scheduler_frame_check.sv
// dht_frame_check: combinational decode and validation of a 40-bit frame.
// Ports: frame_i (frame in), frame_ok_o, hum/temp int/dec bytes out.
// Optional HUM_RANGE_CHECK_EN also rejects hum_int > 100 or hum_dec > 9.
module dht_frame_check
   import humidity_pkg::*;
(
   input  logic [39:0] frame_i,
   output logic        frame_ok_o,
   output logic [7:0]  hum_int_o,
   output logic [7:0]  hum_dec_o,
   output logic [7:0]  temp_int_o,
   output logic [7:0]  temp_dec_o
);

   logic [7:0] csum;
   logic [7:0] sum;

   assign hum_int_o  = frame_byte(frame_i, BYTE_HUM_INT);
   assign hum_dec_o  = frame_byte(frame_i, BYTE_HUM_DEC);
   assign temp_int_o = frame_byte(frame_i, BYTE_TEMP_INT);
   assign temp_dec_o = frame_byte(frame_i, BYTE_TEMP_DEC);
   assign csum       = frame_byte(frame_i, BYTE_CSUM);

   // 8-bit sum: carries out of the byte are dropped
   assign sum = hum_int_o + hum_dec_o + temp_int_o + temp_dec_o;

`ifdef HUM_RANGE_CHECK_EN
   assign frame_ok_o = (sum == csum)
                     && (hum_int_o <= 8'd100)
                     && (hum_dec_o <= 8'd9);
`else
   assign frame_ok_o = (sum == csum);
`endif

endmodule

// File: rtl/humidity_poll_scheduler.sv
// Schedules and supervises humidity sensor reads: periodic or on-demand
// triggers, timeout, checksum validation, retry and fault reporting.
// Inputs: clk1M, rst (async high), req, rd_state[2:0], rd_data[39:0].
// Outputs: trig_out, hum/temp int/dec, data_valid, sensor_fault,
// err_cnt[7:0], busy. Build macro: HUM_RANGE_CHECK_EN (range check).
module humidity_poll_scheduler
   import humidity_pkg::*;
#(
   parameter int unsigned PERIOD_CYC  = 5000000,
   parameter int unsigned MIN_GAP_CYC = 2000000,
   parameter int unsigned TIMEOUT_CYC = 30000,
   parameter int unsigned TRIG_CYC    = 4,
   parameter int unsigned MAX_RETRY   = 2
) (
   input  logic        clk1M,
   input  logic        rst,
   input  logic        req,
   input  logic [2:0]  rd_state,
   input  logic [39:0] rd_data,
   output logic        trig_out,
   output logic [7:0]  hum_int,
   output logic [7:0]  hum_dec,
   output logic [7:0]  temp_int,
   output logic [7:0]  temp_dec,
   output logic        data_valid,
   output logic        sensor_fault,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   state_e      state_q;
   logic [31:0] per_q;
   logic [31:0] gap_q;
   logic [31:0] to_q;
   logic [31:0] retry_q;
   logic [39:0] frame_q;
   logic        pend_q;
   logic        trig_q;
   logic        busy_q;
   logic        dv_q;
   logic        fault_q;
   logic [7:0]  err_q;
   logic [7:0]  hi_q, hd_q, ti_q, td_q;

   logic        tick, gap_ok, tout, started;
   logic        start_go, fail;
   logic        frame_ok;
   logic [7:0]  f_hi, f_hd, f_ti, f_td;

   dht_frame_check u_check (
      .frame_i    (frame_q),
      .frame_ok_o (frame_ok),
      .hum_int_o  (f_hi),
      .hum_dec_o  (f_hd),
      .temp_int_o (f_ti),
      .temp_dec_o (f_td)
   );

   assign tick    = (per_q == PERIOD_CYC - 1);
   // The edge that launches the next trigger completes the gap,
   // so triggers land exactly MIN_GAP_CYC cycles apart.
   assign gap_ok  = (gap_q >= MIN_GAP_CYC - 1);
   assign tout    = (to_q >= TIMEOUT_CYC - 1);
   assign started = (rd_state == RD_START) || (rd_state == RD_RX);

   assign start_go = ((state_q == IDLE) && (tick || req || pend_q) && gap_ok)
                   || ((state_q == BACKOFF) && gap_ok);

   assign fail = ((state_q == WAIT_START) && !started && tout)
               || ((state_q == WAIT_DONE) && (rd_state != RD_DONE) && tout)
               || ((state_q == CHECK) && !frame_ok);

   always_ff @(posedge clk1M or posedge rst) begin
      if (rst) begin
         per_q <= '0;
         gap_q <= '0;
      end else begin
         per_q <= tick ? '0 : per_q + 32'd1;
         if (start_go)
            gap_q <= '0;
         else if (gap_q < MIN_GAP_CYC)
            gap_q <= gap_q + 32'd1;
      end
   end

   always_ff @(posedge clk1M or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         to_q    <= '0;
         retry_q <= '0;
         frame_q <= '0;
         pend_q  <= 1'b0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         dv_q    <= 1'b0;
         fault_q <= 1'b0;
         err_q   <= '0;
         hi_q    <= '0;
         hd_q    <= '0;
         ti_q    <= '0;
         td_q    <= '0;
      end else begin
         dv_q <= 1'b0;
         if (state_q != IDLE)
            to_q <= to_q + 32'd1;

         // Only one request is remembered; triggering from IDLE serves it
         if ((state_q == IDLE) && start_go)
            pend_q <= 1'b0;
         else if (req)
            pend_q <= 1'b1;

         unique case (state_q)
            IDLE, BACKOFF: begin
               if (start_go) begin
                  state_q <= TRIG;
                  trig_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  to_q    <= '0;
               end
            end
            TRIG: begin
               if (to_q == TRIG_CYC - 1) begin
                  state_q <= WAIT_START;
                  trig_q  <= 1'b0;
               end
            end
            WAIT_START: begin
               if (started)
                  state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (rd_state == RD_DONE) begin
                  frame_q <= rd_data;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               if (frame_ok) begin
                  hi_q    <= f_hi;
                  hd_q    <= f_hd;
                  ti_q    <= f_ti;
                  td_q    <= f_td;
                  dv_q    <= 1'b1;
                  fault_q <= 1'b0;
                  retry_q <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               trig_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase

         if (fail) begin
            if (err_q != 8'hFF)
               err_q <= err_q + 8'd1;
            if (retry_q < MAX_RETRY) begin
               retry_q <= retry_q + 32'd1;
               state_q <= BACKOFF;
            end else begin
               fault_q <= 1'b1;
               retry_q <= '0;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         end
      end
   end

   assign trig_out     = trig_q;
   assign busy         = busy_q;
   assign data_valid   = dv_q;
   assign sensor_fault = fault_q;
   assign err_cnt      = err_q;
   assign hum_int      = hi_q;
   assign hum_dec      = hd_q;
   assign temp_int     = ti_q;
   assign temp_dec     = td_q;

endmodule

// File: tb/tb_humidity_poll_scheduler.sv
// Self-checking bench for humidity_poll_scheduler with a behavioural
// reader model; shortened timing parameters keep the run small.
module tb_humidity_poll_scheduler;

   localparam int P  = 3000;
   localparam int G  = 80;
   localparam int T  = 30;
   localparam int TC = 4;

   logic        clk1M = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic [2:0]  rd_state;
   logic [39:0] rd_data;
   logic        trig_out, data_valid, sensor_fault, busy;
   logic [7:0]  hum_int, hum_dec, temp_int, temp_dec, err_cnt;

   always #5 clk1M = ~clk1M;

   humidity_poll_scheduler #(
      .PERIOD_CYC  (P),
      .MIN_GAP_CYC (G),
      .TIMEOUT_CYC (T),
      .TRIG_CYC    (TC),
      .MAX_RETRY   (2)
   ) dut (
      .clk1M        (clk1M),
      .rst          (rst),
      .req          (req),
      .rd_state     (rd_state),
      .rd_data      (rd_data),
      .trig_out     (trig_out),
      .hum_int      (hum_int),
      .hum_dec      (hum_dec),
      .temp_int     (temp_int),
      .temp_dec     (temp_dec),
      .data_valid   (data_valid),
      .sensor_fault (sensor_fault),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0, trig_n = 0, dv_n = 0;
   int   rise_cyc = 0, prev_rise = 0, last_w = 0;
   logic trig_d = 1'b0;

   always @(posedge clk1M) begin
      cyc    <= cyc + 1;
      trig_d <= trig_out;
      if (data_valid) dv_n <= dv_n + 1;
      if (trig_out && !trig_d) begin
         trig_n    <= trig_n + 1;
         prev_rise <= rise_cyc;
         rise_cyc  <= cyc;
      end
      if (!trig_out && trig_d) last_w <= cyc - rise_cyc;
   end

   // Reader model: answers each trigger, optionally corrupting the
   // first attempts or hanging in the receive state.
   logic [39:0] frame_m = '0;
   int          bad_until = 0;
   int          att_n = 0;
   logic        stuck = 1'b0;

   initial begin
      rd_state = 3'd0;
      rd_data  = '0;
      forever begin
         @(posedge trig_out);
         if (stuck) begin
            #1 rd_state = 3'd2;
            while (stuck) @(posedge clk1M);
            #1 rd_state = 3'd0;
         end else begin
            repeat (2) @(posedge clk1M);
            #1 rd_state = 3'd1;
            repeat (2) @(posedge clk1M);
            #1 rd_state = 3'd2;
            repeat (8) @(posedge clk1M);
            #1 rd_state = 3'd3;
            rd_data = (att_n < bad_until) ? (frame_m ^ 40'h1) : frame_m;
            att_n++;
            @(posedge clk1M);
            #1 rd_state = 3'd0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk1M);
      #1;
   endtask

   task automatic pulse_req();
      req = 1'b1;
      step(1);
      req = 1'b0;
   endtask

   task automatic wait_trig(input int n0);
      int k = 0;
      while (trig_n == n0 && k < 400) begin step(1); k++; end
      if (trig_n == n0) chk("trig_wait", 0, 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 1000) begin step(1); k++; end
      if (busy) chk("idle_wait", 1, 0);
   endtask

   task automatic poll_trig_hi();
      int k = 0;
      while (!trig_out && k < 400) begin step(1); k++; end
      if (!trig_out) chk("trig_hi_wait", 0, 1);
   endtask

   task automatic run_txn();
      int n0;
      n0 = trig_n;
      pulse_req();
      wait_trig(n0);
      wait_idle();
      step(2);
   endtask

   typedef struct {
      logic [39:0] frame;
      int          dv;
      logic [7:0]  hi, hd, ti, td;
      logic        flt;
      logic [7:0]  err;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int n0, dv0, k;

      tbl[0] = '{40'h3C00190055, 1, 8'd60, 8'd0, 8'd25, 8'd0, 1'b0, 8'd0};
      tbl[1] = '{40'h3C00190056, 0, 8'd60, 8'd0, 8'd25, 8'd0, 1'b1, 8'd3};
      tbl[2] = '{40'h41051A0363, 1, 8'd65, 8'd5, 8'd26, 8'd3, 1'b0, 8'd3};
      tbl[3] = '{40'h6309FFFF6A, 1, 8'd99, 8'd9, 8'd255, 8'd255, 1'b0, 8'd3};
      tbl[4] = '{40'h0000000001, 0, 8'd99, 8'd9, 8'd255, 8'd255, 1'b1, 8'd6};
      tbl[5] = '{40'h0000000000, 1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd6};

      step(3);
      chk("rst_trig", trig_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_hum_int", hum_int, 0);
      chk("rst_hum_dec", hum_dec, 0);
      chk("rst_temp_int", temp_int, 0);
      chk("rst_temp_dec", temp_dec, 0);
      chk("rst_fault", sensor_fault, 0);
      chk("rst_err", err_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         frame_m   = tbl[i].frame;
         bad_until = att_n;
         dv0       = dv_n;
         run_txn();
         chk($sformatf("v%0d_dv", i), dv_n - dv0, tbl[i].dv);
         chk($sformatf("v%0d_hum_int", i), hum_int, tbl[i].hi);
         chk($sformatf("v%0d_hum_dec", i), hum_dec, tbl[i].hd);
         chk($sformatf("v%0d_temp_int", i), temp_int, tbl[i].ti);
         chk($sformatf("v%0d_temp_dec", i), temp_dec, tbl[i].td);
         chk($sformatf("v%0d_fault", i), sensor_fault, tbl[i].flt);
         chk($sformatf("v%0d_err", i), err_cnt, tbl[i].err);
      end

      // one bad attempt, then the retry succeeds
      frame_m   = 40'h3C00190055;
      bad_until = att_n + 1;
      n0  = trig_n;
      dv0 = dv_n;
      run_txn();
      chk("retry_trigs", trig_n - n0, 2);
      chk("retry_gap", rise_cyc - prev_rise, G);
      chk("retry_dv", dv_n - dv0, 1);
      chk("retry_err", err_cnt, 7);
      chk("retry_fault", sensor_fault, 0);
      chk("retry_hum", hum_int, 60);

      // reader hangs in receive: three timeouts, then fault
      stuck = 1'b1;
      n0  = trig_n;
      dv0 = dv_n;
      pulse_req();
      poll_trig_hi();
      step(T - 1);
      chk("to_before", err_cnt, 7);
      step(1);
      chk("to_at", err_cnt, 8);
      wait_idle();
      chk("stuck_err", err_cnt, 10);
      chk("stuck_fault", sensor_fault, 1);
      chk("stuck_trigs", trig_n - n0 + 0, 3);
      chk("stuck_dv", dv_n - dv0, 0);
      chk("stuck_hum", hum_int, 60);
      chk("stuck_temp", temp_int, 25);
      stuck = 1'b0;
      step(2);

      // request shortly after a trigger waits for the gap
      n0  = trig_n;
      dv0 = dv_n;
      pulse_req();
      poll_trig_hi();
      step(20);
      pulse_req();
      k = 21;
      while (!trig_out && k < 200) begin step(1); k++; end
      chk("early_req_gap", k, G);
      wait_idle();
      step(2);
      chk("early_trigs", trig_n - n0, 2);
      chk("early_dv", dv_n - dv0, 2);
      chk("early_fault", sensor_fault, 0);

      // humidity 101 with a correct checksum
      frame_m   = 40'h650019007E;
      bad_until = att_n;
      dv0 = dv_n;
      run_txn();
`ifdef HUM_RANGE_CHECK_EN
      chk("range_err", err_cnt, 13);
      chk("range_fault", sensor_fault, 1);
      chk("range_dv", dv_n - dv0, 0);
      chk("range_hum", hum_int, 60);
`else
      chk("range_err", err_cnt, 10);
      chk("range_fault", sensor_fault, 0);
      chk("range_dv", dv_n - dv0, 1);
      chk("range_hum", hum_int, 101);
`endif

      // reset while waiting for the reader to finish
      frame_m = 40'h3C00190055;
      pulse_req();
      poll_trig_hi();
      step(8);
      rst = 1'b1;
      #1;
      chk("mid_rst_trig", trig_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_hum", hum_int, 0);
      chk("mid_rst_temp", temp_int, 0);
      chk("mid_rst_err", err_cnt, 0);
      chk("mid_rst_fault", sensor_fault, 0);
      step(3);
      rst = 1'b0;
      k = 0;
      while (!trig_out && k < P + 50) begin step(1); k++; end
      chk("first_tick", k, P);

      // request landing on the period tick gives a single trigger
      step(P - 1);
      n0 = trig_n;
      pulse_req();
      chk("coinc_trig", trig_out, 1);
      step(200);
      chk("coinc_count", trig_n - n0, 1);
      chk("trig_width", last_w, TC);
      chk("final_err", err_cnt, 0);
      chk("final_hum", hum_int, 60);
      chk("final_fault", sensor_fault, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/humidity_poll_scheduler.md
Name: humidity_poll_scheduler

Overview:
Sequences the single-wire humidity sensor reader, replacing the free-running 5 s strobe. Issues measurement triggers periodically or on demand and supervises each transaction through the reader's state output. Validates the 40-bit frame (checksum, optional range check), retries on failure and publishes decoded humidity/temperature with a valid strobe and a fault flag. Sits between the reader and the display/control logic.

Parameters:
PERIOD_CYC, 5000000, clk1M cycles between scheduled measurements (5 s at 1 MHz)
MIN_GAP_CYC, 2000000, minimum cycles between any two triggers (sensor recovery time)
TIMEOUT_CYC, 30000, maximum cycles from trigger to reader done before the attempt fails
TRIG_CYC, 4, cycles trig_out is held high (the reader uses 2-flop edge detection)
MAX_RETRY, 2, extra attempts after a failed first attempt before declaring a fault

Ports:
clk1M  input  1  1 MHz system clock
rst  input  1  asynchronous, active-high reset
req  input  1  on-demand measurement request, single-cycle pulse
rd_state  input  3  reader state: 0 idle, 1 start pulse, 2 receiving, 3 done
rd_data  input  40  reader frame: [39:32] hum_int, [31:24] hum_dec, [23:16] temp_int, [15:8] temp_dec, [7:0] checksum
trig_out  output  1  trigger to the reader's strobe input
hum_int  output  8  last valid humidity, integer part
hum_dec  output  8  last valid humidity, decimal part
temp_int  output  8  last valid temperature, integer part
temp_dec  output  8  last valid temperature, decimal part
data_valid  output  1  one-cycle pulse when the outputs update
sensor_fault  output  1  high after all retries fail; cleared by the next good frame
err_cnt  output  8  saturating count of failed attempts
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0. State goes to IDLE. Period and gap counters go to 0. The retry counter goes to 0. Reset is legal mid-transaction; trig_out drops immediately.
- Period counter: free-running; it wraps at PERIOD_CYC-1 and raises the tick. The first scheduled trigger comes PERIOD_CYC cycles after reset. The gap counter saturates at MIN_GAP_CYC and clears on each trigger.
- IDLE: on the tick or on req, with the gap satisfied, go to TRIG. If tick and req coincide, one measurement is made. A req blocked by the gap is latched as pending and served once the gap is met. A req while busy sets pending; it does not queue multiple requests.
- TRIG: trig_out=1 for TRIG_CYC cycles, then go to WAIT_START; trig_out=0. The timeout counter starts at entry to TRIG.
- WAIT_START: wait for rd_state==1 or 2, i.e. the reader has left its done/idle state. Then go to WAIT_DONE.
- WAIT_DONE: when rd_state==3, go to CHECK. rd_data is valid in the same cycle and is captured into a local register.
- Timeout: in WAIT_START or WAIT_DONE, reaching TIMEOUT_CYC counts as a failed attempt.
- CHECK (1 cycle): the frame is good when the checksum equals the sum of the four data bytes mod 256.
  - Good frame: update the four data outputs, pulse data_valid, clear sensor_fault, clear retries, go to IDLE.
  - Bad frame: count a failure.
- Failure handling: err_cnt increments, saturating at 255.
  - If retries < MAX_RETRY: increment retries and go to BACKOFF.
  - Otherwise: set sensor_fault, clear retries, go to IDLE. The data outputs hold their last good values.
- BACKOFF: wait until the gap counter reaches MIN_GAP_CYC, then go to TRIG. A scheduled tick during BACKOFF or WAIT states is dropped, not queued.
- Arithmetic: checksum uses an 8-bit sum with carries discarded. Counters are 32 bits wide.

Optional Feature:
HUM_RANGE_CHECK_EN
- Defined: CHECK also rejects the frame if hum_int > 100 or hum_dec > 9, counted as a failure like a checksum error.
- Undefined: checksum only, and no comparator logic is built.

Decomposition:
- Package humidity_pkg holds:
  - the state enum: IDLE, TRIG, WAIT_START, WAIT_DONE, CHECK, BACKOFF;
  - the rd_state encodings RD_IDLE=0, RD_START=1, RD_RX=2, RD_DONE=3;
  - frame byte-index constants.
- Sub-module dht_frame_check (combinational): input is the 40-bit frame; outputs are frame_ok and the four decoded bytes. It contains the checksum and the optional range check.

Test Plan:
- Good frame: trigger, rd_state 1→2→3, rd_data=0x3C_00_19_00_55 → data_valid pulse; hum_int=60, temp_int=25, sensor_fault=0, err_cnt=0.
- Bad checksum: rd_data=0x3C_00_19_00_56 → no data_valid, err_cnt=1. A retry trigger comes MIN_GAP_CYC after the previous trigger, and a good frame on the retry gives data_valid.
- Stuck reader: rd_state held at 2 → timeout after 30000 cycles; three attempts, then sensor_fault=1 and err_cnt=3. The previous output values are kept.
- Early request: req pulse 100 cycles after a trigger → no new trigger until 2000000 cycles; req coinciding with a period tick → exactly one trig_out pulse of 4 cycles.
- Reset mid-run: assert rst during WAIT_DONE → all outputs 0, IDLE. The next trigger comes PERIOD_CYC cycles after rst is released.
- With HUM_RANGE_CHECK_EN: rd_data=0x65_00_19_00_7E (hum 101, checksum correct) → rejected, err_cnt=1.
